if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues requests to instruction memory over a valid/ready handshake, with at most one request outstanding. It holds one fetched instruction in an output buffer and presents that instruction's decoded fields and immediate to the IF/ID register. It honours stall from the hazard unit and redirect (branch/jump) from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0013, buffer contents while empty or after reset (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_if  in  1  hazard unit: hold the current buffered instruction
redirect_valid  in  1  one-cycle pulse from EX: fetch restarts at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response data valid, at least 1 cycle after acceptance
imem_rsp_data  in  32  instruction word
valid_if  out  1  buffered instruction valid
pc_if  out  32  PC of buffered instruction
pc_plus_4_if  out  32  pc_if + 4, modulo 2^32
opcode_if  out  7  inst[6:0]
rd_if  out  5  inst[11:7]
func_3_if  out  3  inst[14:12]
rs1_if  out  5  inst[19:15]
rs2_if  out  5  inst[24:20]
func_7_bit_6_if  out  1  inst[30]
im_data_if  out  32  sign-extended immediate

Behaviour:
- Registers: fetch_pc, buf_insn, buf_pc, buf_valid, state {FETCH, WAIT}, drop.
- Reset (async, rst_n=0): fetch_pc=RESET_PC, buf_pc=RESET_PC, buf_insn=NOP_INSN, buf_valid=0, state=FETCH, drop=0, imem_req_valid=0. All outputs are derived from these values; pc_plus_4_if=RESET_PC+4. Reset mid-request abandons the request; any later response is ignored until a new request is issued.
- consume = buf_valid & ~stall_if. The IF/ID register captures the instruction on that edge.
- FETCH: imem_req_valid = ~buf_valid | consume; imem_req_addr = fetch_pc. On acceptance (valid & ready): fetch_pc <= fetch_pc+4, state <= WAIT.
- WAIT: imem_req_valid=0. When imem_rsp_valid is high:
  - drop=0: buf_insn <= data, buf_pc <= the address of that request, buf_valid <= 1, state <= FETCH.
  - drop=1: data discarded, drop <= 0, state <= FETCH.
- The buffer is always empty when a response arrives. Requests are only issued when the slot is free or is being freed that cycle.
- buf_valid clears on consume unless refilled by a response on the same edge.
- Redirect has priority over everything:
  - buf_valid <= 0 and fetch_pc <= {redirect_pc[31:2],2'b00}.
  - In WAIT, or in FETCH with a request accepted on the same edge: drop <= 1, state <= WAIT.
  - In FETCH with no acceptance: the next request uses the new PC. imem_req_addr may change without acceptance only in this case.
  - Redirect and stall together: the redirect wins.
- Stall with buf_valid=0 has no effect on fetch.
- Best-case throughput is 1 instruction per 2 cycles with single-cycle memory.
- Immediate, selected by opcode:
  - I-type (0000011, 0010011, 1100111, 1110011): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25],inst[11:7]}).
  - B-type (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U-type (0110111, 0010111): {inst[31:12],12'b0}.
  - J-type (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode: 0.
- Fields and im_data_if are combinational from buf_insn. They are valid whenever valid_if=1 and are don't-care otherwise (NOP decode).

Test Plan:
- Reset release, ready=1, 1-cycle response of 0x00500093 -> first request addr 0x0; valid_if=1 with pc_if=0, rd_if=1, im_data_if=5; next request addr 0x4.
- stall_if held 3 cycles while valid_if=1 -> outputs stable, no new request; request for 0x8 issued on the cycle stall drops.
- redirect_valid with redirect_pc=0x103 while in WAIT -> the old response is discarded, valid_if stays 0, the next request addr is 0x100.
- Redirect on the same cycle a request is accepted -> the response to that request is dropped; the next request uses the redirect target.
- Immediate decode: 0xFE000EE3 (beq, offset -4) -> im_data_if=0xFFFFFFFC; 0x123450B7 (lui) -> 0x12345000; 0x0000006F (jal) -> 0.
- Wrap: redirect to 0xFFFFFFFC -> pc_plus_4_if=0x0, next request 0x0; rst_n asserted in WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and imem (slave).
// One request channel (valid/ready/addr) and one response channel (valid/data).
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a single-entry output
// buffer, and field/immediate decode of the buffered word for the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic              valid_if,
    output logic [31:0]       pc_if,
    output logic [31:0]       pc_plus_4_if,
    output logic [6:0]        opcode_if,
    output logic [4:0]        rd_if,
    output logic [2:0]        func_3_if,
    output logic [4:0]        rs1_if,
    output logic [4:0]        rs2_if,
    output logic              func_7_bit_6_if,
    output logic [31:0]       im_data_if
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] buf_insn;
    logic [31:0] buf_pc;
    logic        buf_valid;
    logic        drop;

    logic        consume;
    logic        req_valid;
    logic        accept;
    logic        rsp_take;

    assign consume  = buf_valid & ~stall_if;
    // Gated by rst_n so no request is presented while reset is held.
    assign req_valid = rst_n & (state == S_FETCH) & (~buf_valid | consume);
    assign accept    = req_valid & imem.imem_req_ready;
    assign rsp_take  = (state == S_WAIT) & imem.imem_rsp_valid;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            buf_insn  <= NOP_INSN;
            buf_pc    <= RESET_PC;
            buf_valid <= 1'b0;
            drop      <= 1'b0;
        end else if (redirect_valid) begin
            buf_valid <= 1'b0;
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            if (state == S_WAIT) begin
                // A response landing with the redirect retires the stale request now.
                if (imem.imem_rsp_valid) begin
                    state <= S_FETCH;
                    drop  <= 1'b0;
                end else begin
                    drop  <= 1'b1;
                end
            end else if (accept) begin
                state <= S_WAIT;
                drop  <= 1'b1;
            end
        end else begin
            if (rsp_take && !drop) begin
                buf_valid <= 1'b1;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_take) begin
                        state <= S_FETCH;
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            buf_insn <= imem.imem_rsp_data;
                            buf_pc   <= fetch_pc - 32'd4;
                        end
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign valid_if        = buf_valid;
    assign pc_if           = buf_pc;
    assign pc_plus_4_if    = buf_pc + 32'd4;
    assign opcode_if       = buf_insn[6:0];
    assign rd_if           = buf_insn[11:7];
    assign func_3_if       = buf_insn[14:12];
    assign rs1_if          = buf_insn[19:15];
    assign rs2_if          = buf_insn[24:20];
    assign func_7_bit_6_if = buf_insn[30];

    always_comb begin
        im_data_if = 32'h0;
        case (buf_insn[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                im_data_if = {{20{buf_insn[31]}}, buf_insn[31:20]};
            7'b0100011:
                im_data_if = {{20{buf_insn[31]}}, buf_insn[31:25], buf_insn[11:7]};
            7'b1100011:
                im_data_if = {{19{buf_insn[31]}}, buf_insn[31], buf_insn[7],
                              buf_insn[30:25], buf_insn[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                im_data_if = {buf_insn[31:12], 12'h000};
            7'b1101111:
                im_data_if = {{11{buf_insn[31]}}, buf_insn[31], buf_insn[19:12],
                              buf_insn[20], buf_insn[30:21], 1'b0};
            default:
                im_data_if = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: imem model, fetch-address model and a queue
// scoreboard of accepted request addresses popped when the stage hands an instruction on.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_if;
    logic [31:0] pc_if;
    logic [31:0] pc_plus_4_if;
    logic [6:0]  opcode_if;
    logic [4:0]  rd_if;
    logic [2:0]  func_3_if;
    logic [4:0]  rs1_if;
    logic [4:0]  rs2_if;
    logic        func_7_bit_6_if;
    logic [31:0] im_data_if;

    if_stage_if imem ();

    if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_if        (stall_if),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (imem),
        .valid_if        (valid_if),
        .pc_if           (pc_if),
        .pc_plus_4_if    (pc_plus_4_if),
        .opcode_if       (opcode_if),
        .rd_if           (rd_if),
        .func_3_if       (func_3_if),
        .rs1_if          (rs1_if),
        .rs2_if          (rs2_if),
        .func_7_bit_6_if (func_7_bit_6_if),
        .im_data_if      (im_data_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          numChecks = 0;
    int          numFails  = 0;
    int          numConsumed = 0;
    int          memLat = 0;
    logic        memPend = 1'b0;
    int          memWait = 0;
    logic [31:0] memAddr = 32'h0;
    logic [31:0] expFetchPc = 32'h0;
    logic [31:0] sb[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a[5:2])
            4'd0:  return 32'h00500093;
            4'd1:  return 32'hFE000EE3;
            4'd2:  return 32'h123450B7;
            4'd3:  return 32'h0000006F;
            4'd4:  return 32'hFE112C23;
            4'd5:  return 32'h80000537;
            4'd6:  return 32'h00001297;
            4'd7:  return 32'h80002083;
            4'd8:  return 32'hFFC08067;
            4'd9:  return 32'h30200073;
            4'd10: return 32'h0080006F;
            4'd11: return 32'hFFDFF0EF;
            4'd12: return 32'h40B50533;
            4'd13: return 32'h00000863;
            4'd14: return 32'h0FF0000F;
            default: return 32'hFFF1F113;
        endcase
    endfunction

    // Hand-decoded immediates for each word of the table above.
    function automatic logic [31:0] immOf(input logic [31:0] a);
        case (a[5:2])
            4'd0:  return 32'h00000005;
            4'd1:  return 32'hFFFFFFFC;
            4'd2:  return 32'h12345000;
            4'd3:  return 32'h00000000;
            4'd4:  return 32'hFFFFFFF8;
            4'd5:  return 32'h80000000;
            4'd6:  return 32'h00001000;
            4'd7:  return 32'hFFFFF800;
            4'd8:  return 32'hFFFFFFFC;
            4'd9:  return 32'h00000302;
            4'd10: return 32'h00000008;
            4'd11: return 32'hFFFFFFFC;
            4'd12: return 32'h00000000;
            4'd13: return 32'h00000010;
            4'd14: return 32'h00000000;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic redir,
                                 input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        stall_if            = stall;
        redirect_valid      = redir;
        redirect_pc         = rpc;
        imem.imem_req_ready = rdy;
    endtask

    task automatic waitValid();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 50 && !valid_if; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("valid_seen", {31'h0, valid_if}, 32'h1);
    endtask

    task automatic waitReq();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 50 && !imem.imem_req_valid; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req_seen", {31'h0, imem.imem_req_valid}, 32'h1);
    endtask

    // Monitor: decides at each negedge what the coming posedge will do.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [31:0] ei;
        if (!rst_n) begin
            sb.delete();
            expFetchPc = 32'h0;
        end else begin
            if (valid_if && stall_if && !redirect_valid)
                checkOutput("req_in_stall", {31'h0, imem.imem_req_valid}, 32'h0);
            if (valid_if && !stall_if && !redirect_valid) begin
                numConsumed++;
                checkOutput("sb_depth", 32'(sb.size()), 32'h1);
                if (sb.size() > 0) begin
                    ea = sb.pop_front();
                    ei = memWord(ea);
                    checkOutput("pc_if", pc_if, ea);
                    checkOutput("pc_plus_4_if", pc_plus_4_if, ea + 32'd4);
                    checkOutput("opcode_if", {25'h0, opcode_if}, {25'h0, ei[6:0]});
                    checkOutput("rd_if", {27'h0, rd_if}, {27'h0, ei[11:7]});
                    checkOutput("func_3_if", {29'h0, func_3_if}, {29'h0, ei[14:12]});
                    checkOutput("rs1_if", {27'h0, rs1_if}, {27'h0, ei[19:15]});
                    checkOutput("rs2_if", {27'h0, rs2_if}, {27'h0, ei[24:20]});
                    checkOutput("func_7_bit_6_if", {31'h0, func_7_bit_6_if}, {31'h0, ei[30]});
                    checkOutput("im_data_if", im_data_if, immOf(ea));
                end
            end
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                checkOutput("req_addr", imem.imem_req_addr, expFetchPc);
                sb.push_back(imem.imem_req_addr);
                expFetchPc = expFetchPc + 32'd4;
                memPend = 1'b1;
                memAddr = imem.imem_req_addr;
                memWait = memLat;
            end
            if (redirect_valid) begin
                sb.delete();
                expFetchPc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    // Memory response driver: answers memLat cycles after acceptance.
    always @(posedge clk) begin
        #1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = $urandom;
        if (memPend) begin
            if (memWait == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = memWord(memAddr);
                memPend = 1'b0;
            end else begin
                memWait--;
            end
        end
    end

    initial begin
        logic [31:0] p;
        rst_n               = 1'b0;
        stall_if            = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid_if", {31'h0, valid_if}, 32'h0);
        checkOutput("rst_pc_if", pc_if, 32'h0);
        checkOutput("rst_pc_plus_4", pc_plus_4_if, 32'h4);
        checkOutput("rst_req_valid", {31'h0, imem.imem_req_valid}, 32'h0);
        checkOutput("rst_opcode", {25'h0, opcode_if}, 32'h13);
        rst_n = 1'b1;
        #1;
        checkOutput("first_req_addr", imem.imem_req_addr, 32'h0);

        waitValid();
        checkOutput("first_pc", pc_if, 32'h0);
        checkOutput("first_rd", {27'h0, rd_if}, 32'h1);
        checkOutput("first_imm", im_data_if, 32'h5);
        checkOutput("second_req_addr", imem.imem_req_addr, 32'h4);

        waitValid();
        stall_if = 1'b1;
        p = pc_if;
        checkOutput("stall_pc", p, 32'h4);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("stall_hold_pc", pc_if, p);
            checkOutput("stall_hold_valid", {31'h0, valid_if}, 32'h1);
            checkOutput("stall_no_req", {31'h0, imem.imem_req_valid}, 32'h0);
        end
        stall_if = 1'b0;
        #1;
        checkOutput("unstall_req", {31'h0, imem.imem_req_valid}, 32'h1);
        checkOutput("unstall_addr", imem.imem_req_addr, 32'h8);

        // Redirect while waiting on a slow response.
        waitReq();
        memLat = 2;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (imem.imem_req_valid) break;
            checkOutput("no_valid_after_redir", {31'h0, valid_if}, 32'h0);
        end
        memLat = 0;
        checkOutput("redir_wait_req", {31'h0, imem.imem_req_valid}, 32'h1);
        checkOutput("redir_wait_addr", imem.imem_req_addr, 32'h100);

        // Redirect on the same edge as an acceptance.
        waitReq();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        waitReq();
        checkOutput("redir_acc_addr", imem.imem_req_addr, 32'h20);
        waitValid();
        checkOutput("redir_acc_pc", pc_if, 32'h20);

        // Wrap-around at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        waitValid();
        checkOutput("wrap_pc", pc_if, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_plus_4", pc_plus_4_if, 32'h0);
        checkOutput("wrap_imm", im_data_if, 32'hFFFF_FFFF);
        checkOutput("wrap_next_addr", imem.imem_req_addr, 32'h0);

        // Reset asserted while a request is outstanding.
        waitReq();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid_if", {31'h0, valid_if}, 32'h0);
        checkOutput("midrst_pc_if", pc_if, 32'h0);
        checkOutput("midrst_pc_plus_4", pc_plus_4_if, 32'h4);
        checkOutput("midrst_req_valid", {31'h0, imem.imem_req_valid}, 32'h0);
        checkOutput("midrst_opcode", {25'h0, opcode_if}, 32'h13);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        waitValid();
        checkOutput("postrst_pc", pc_if, 32'h0);

        // Random traffic: stalls, backpressure, variable latency and redirects.
        for (int i = 0; i < 400; i++) begin
            memLat = $urandom_range(0, 2);
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
                          $urandom, ($urandom_range(0, 9) < 7));
        end
        memLat = 0;
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("enough_consumed", {31'h0, (numConsumed >= 60)}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
